// File: rtl/nw_pkg.sv
// Shared types and helpers for the Needleman-Wunsch fill datapath.
package nw_pkg;

    localparam int SCORE_W = 32;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ISSUE,
        ST_CAPTURE,
        ST_DONE
    } nw_state_t;

    // n * gap by shift-and-add. Only used for the degenerate single-row or
    // single-column matrices, where there are no PE cycles to accumulate over.
    function automatic score_t scale_gap(input score_t gap, input logic [15:0] n);
        score_t acc;
        acc = '0;
        for (int k = 0; k < 16; k++) begin
            if (n[k]) begin
                acc = acc + (gap <<< k);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/nw_row_buffer.sv
// Previous-row score store: one combinational read port, one synchronous
// write port. A read of the index being written returns the old contents.
module nw_row_buffer
    import nw_pkg::*;
#(
    parameter int DEPTH  = 17,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  score_t            wdata,
    input  logic [ADDR_W-1:0] raddr,
    output score_t            rdata
);

    score_t mem [DEPTH];

    // Write port; contents are fully rewritten by the INIT sweep of every run.
    // NOTE: storage is deliberately not reset -- every entry is written before it is read, and a reset would turn the array into flops with a huge reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nw_fill_scheduler.sv
// Row-major Needleman-Wunsch matrix fill sequencer driving one PE with a
// fixed one-cycle latency. Column 0 of each row is tracked in a running
// boundary register; columns 1..len_b of the previous row live in the buffer.
module nw_fill_scheduler
    import nw_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [IDX_W-1:0]          len_a,
    input  logic [IDX_W-1:0]          len_b,
    input  logic signed [SCORE_W-1:0] gap_penalty,
    output logic [IDX_W-1:0]          seq_a_addr,
    output logic [IDX_W-1:0]          seq_b_addr,
    output logic                      pe_start,
    output logic signed [SCORE_W-1:0] pe_prev_diagonal,
    output logic signed [SCORE_W-1:0] pe_prev_horizontal,
    output logic signed [SCORE_W-1:0] pe_prev_vertical,
    input  logic signed [SCORE_W-1:0] pe_next,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic signed [SCORE_W-1:0] score
);

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_LEN);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    nw_state_t        state;
    logic [IDX_W-1:0] lat_a;
    logic [IDX_W-1:0] lat_b;
    score_t           gap;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    score_t           acc;    // j*gap during the INIT sweep
    score_t           bnd;    // H[i][0] of the current row
    score_t           diag;   // H[i-1][j-1] for the next issue
    score_t           left;   // H[i][j-1] for the next issue

    logic             buf_we;
    score_t           buf_wdata;
    score_t           buf_rdata;

    nw_row_buffer #(
        .DEPTH  (MAX_LEN + 1),
        .ADDR_W (IDX_W)
    ) u_row_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (j),
        .wdata (buf_wdata),
        .raddr (j),
        .rdata (buf_rdata)
    );

    // Row buffer write: boundary row during INIT, PE result during CAPTURE.
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        buf_we    = 1'b0;
        buf_wdata = acc;
        case (state)
            ST_INIT:    buf_we = 1'b1;
            ST_CAPTURE: begin
                buf_we    = 1'b1;
                buf_wdata = pe_next;
            end
            default: ;
        endcase
    end

    assign pe_prev_diagonal   = diag;
    assign pe_prev_horizontal = left;
    assign pe_prev_vertical   = pe_start ? buf_rdata : '0;

    // Fill sequencer: IDLE -> INIT sweep -> ISSUE/CAPTURE per cell -> DONE.
    // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_a      <= '0;
            lat_b      <= '0;
            gap        <= '0;
            i          <= '0;
            j          <= '0;
            acc        <= '0;
            bnd        <= '0;
            diag       <= '0;
            left       <= '0;
            seq_a_addr <= '0;
            seq_b_addr <= '0;
            pe_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            score      <= '0;
        end else begin
            pe_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_a <= len_a;
                        lat_b <= len_b;
                        gap   <= gap_penalty;
                        err   <= 1'b0;
                        score <= '0;
                        if (len_a > MAX_IDX || len_b > MAX_IDX) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            busy  <= 1'b1;
                            j     <= '0;
                            acc   <= '0;
                            state <= ST_INIT;
                        end
                    end
                end

                ST_INIT: begin
                    if (j == lat_b) begin
                        if (lat_a == '0 || lat_b == '0) begin
                            score <= scale_gap(gap, 16'(lat_a) + 16'(lat_b));
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            i          <= ONE_IDX;
                            j          <= ONE_IDX;
                            diag       <= '0;
                            left       <= gap;
                            bnd        <= gap;
                            seq_a_addr <= '0;
                            seq_b_addr <= '0;
                            pe_start   <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end else begin
                        j   <= j + ONE_IDX;
                        acc <= acc + gap;
                    end
                end

                ST_ISSUE: begin
                    state <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    diag <= buf_rdata;
                    left <= pe_next;
                    if (j != lat_b) begin
                        j          <= j + ONE_IDX;
                        seq_b_addr <= j;
                        pe_start   <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (i != lat_a) begin
                        i          <= i + ONE_IDX;
                        j          <= ONE_IDX;
                        diag       <= bnd;
                        left       <= bnd + gap;
                        bnd        <= bnd + gap;
                        seq_a_addr <= i;
                        seq_b_addr <= '0;
                        pe_start   <= 1'b1;
                        state      <= ST_ISSUE;
                    end else begin
                        score <= pe_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nw_fill_scheduler.md
# nw_fill_scheduler

Sequencer that fills a Needleman-Wunsch score matrix with one `processing_unit` instance. It walks the (len_a+1)×(len_b+1) matrix row-major, generates the gap-penalty boundary row and column, and keeps the previous row in an internal buffer. For each cell it presents the diagonal, horizontal and vertical neighbours to the PE and collects the PE result. It sits between the alignment top level and the PE and returns the final cell H[len_a][len_b].

## Interface
- `MAX_LEN`, default 16: maximum sequence length accepted.
- `IDX_W`, default $clog2(MAX_LEN+1): width of length and index buses.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; returns to IDLE.
- `start`  in  1  request; sampled only in IDLE.
- `len_a`, `len_b`  in  IDX_W  sequence lengths; latched on accepted start.
- `gap_penalty`  in  32 signed  latched on accepted start; used for boundaries.
- `seq_a_addr`, `seq_b_addr`  out  IDX_W  character indices (i-1, j-1) to external async-read sequence memories. Read data drives the PE `a`/`b` ports directly.
- `pe_start`  out  1  compute strobe to the PE.
- `pe_prev_diagonal`, `pe_prev_horizontal`, `pe_prev_vertical`  out  32 signed  neighbour scores H[i-1][j-1], H[i][j-1], H[i-1][j].
- `pe_next`  in  32 signed  PE result, valid the cycle after `pe_start`.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse when the result is ready.
- `err`  out  1  set with done if a length exceeds MAX_LEN; held until next accepted start.
- `score`  out  32 signed  final H[len_a][len_b]; held until next accepted start.

## Operation
- States: IDLE, INIT, ISSUE, CAPTURE, DONE.
- IDLE: start=1 latches len_a, len_b and gap, and clears err.
  - Either length > MAX_LEN → DONE with err=1, score=0.
  - Otherwise → INIT with j=0.
- INIT: writes row_buf[j] = j·gap for j=0..len_b, one entry per cycle. After the last entry:
  - len_a=0 or len_b=0 → DONE with score=(len_a+len_b)·gap.
  - Otherwise → ISSUE with i=1, j=1, left=gap, diag=row_buf[0]=0, and row_buf[0] updated to gap.
- ISSUE:
  - pe_start=1, seq addrs = i-1 and j-1.
  - diagonal=diag, horizontal=left, vertical=row_buf[j].
  - → CAPTURE.
- CAPTURE: diag←row_buf[j] (old value), row_buf[j]←pe_next, left←pe_next. Then one of:
  - j<len_b → j+1, ISSUE.
  - j=len_b and i<len_a → i+1, j=1, left=(i+1)·gap, diag=row_buf[0], row_buf[0]←(i+1)·gap, ISSUE.
  - last cell → score←pe_next, DONE.
- DONE: done=1 for one cycle, → IDLE.
- Arithmetic: signed 32-bit two's complement, wrap on overflow, no saturation. Boundary values i·gap come from accumulating gap per row (no multiplier).
- PE `done` is sticky and is not used; the scheduler relies on the fixed 1-cycle PE latency.
- start while busy is ignored.
- match_score, mismatch_penalty and gap_penalty on the PE must be stable while busy.

## Timing
- Reset values: pe_start=0, busy=0, done=0, err=0, score=0, all pe_prev_* =0, addresses=0, state IDLE. Row buffer contents are don't-care.
- Let start be sampled at edge E0. done is high in cycle N after E0:
  - Normal case: N = len_b + 2 + 2·len_a·len_b. This holds for zero lengths too.
  - err case: N = 1.
- Throughput is one cell per 2 cycles. The horizontal dependency forces the ISSUE/CAPTURE alternation.
- Reset mid-run: next cycle is IDLE with all outputs at reset values. The aborted run produces no done.
- start in the DONE cycle is ignored; start is accepted from the following IDLE cycle.

## Structure
- Package `nw_pkg`: SCORE_W=32, state enum `nw_state_t`, shared with the PE array and top level.
- Sub-module `nw_row_buffer`: MAX_LEN+1 × 32 register file with one read port (combinational) and one write port. Write-then-read of the same index in the same cycle returns the old data.

## Test plan
Common settings: match=1, mismatch=-1, gap=-2, MAX_LEN=16.
- a="A", b="A": score=1, done at E0+5, err=0.
- a="AC", b="AG": score=0, done at E0+12. Check pe_prev_* at the first ISSUE: diag=0, horz=-2, vert=-2.
- a="ACGT", b="ACGT": score=4, done at E0+38, busy high for cycles 1..37.
- len_a=0, len_b=3: score=-6, done at E0+5.
- len_a=3, len_b=0: score=-6, done at E0+2, no pe_start ever.
- len_a=17: done at E0+1 with err=1, score=0.
- Reset asserted mid-run: IDLE next cycle with no done. A later run of "A"/"C" gives score=-1.
- start pulses while busy: the result is unchanged.
